// File: rtl/audio_frame_loader_if.sv
// Sample stream handshake between the audio source and audio_frame_loader.
// master drives data/valid, slave answers with ready.
interface audio_frame_loader_if #(
    parameter int SAMPLE_W = 32
);
    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/audio_frame_loader.sv
// audio_frame_loader: collects N samples into a flat frame bus, pulses start,
// then holds the frame and its validated interval length until the min/max
// stage reports done (seen as a fresh low->high level of mm_done).
// Optional feature macro: AUDIO_LOADER_CLIP_COUNT_EN (per-frame clip counter).
module audio_frame_loader #(
    parameter int                  N            = 100,
    parameter int                  SAMPLE_W     = 32,
    parameter logic [15:0]         INTERVAL_LEN = 16'd10,
    parameter logic [SAMPLE_W-1:0] CLIP_THRESH  = SAMPLE_W'(32'h7FFF0000)
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_frame_loader_if.slave   s_if,
    input  logic                  flush,
    input  logic [15:0]           cfg_interval_len,
    input  logic                  mm_done,
    output logic [N*SAMPLE_W-1:0] raw_audio,
    output logic [15:0]           interval_len,
    output logic                  start,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [15:0]           frame_count,
    output logic [15:0]           clip_count
);
    localparam int          PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] N_U32 = 32'(N);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_DONE
    } state_t;

    state_t           state, state_n;
    logic [PTR_W-1:0] wr_ptr;
    logic             s_ready_q;
    logic             accept;
    logic             do_flush;
    logic             last;
    logic [31:0]      cfg_div;
    logic [31:0]      cfg_rem;
    logic             cfg_ok;

    assign s_if.s_ready = s_ready_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_FILL;
        else       state <= state_n;
    end

    // Next state plus write/flush qualifiers; flush beats a same-cycle sample.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        do_flush = 1'b0;
        last     = 1'b0;
        case (state)
            ST_FILL: begin
                if (flush) begin
                    do_flush = 1'b1;
                end else if (s_if.s_valid && s_ready_q) begin
                    accept = 1'b1;
                    if (wr_ptr == PTR_W'(N - 1)) begin
                        last    = 1'b1;
                        state_n = ST_START;
                    end
                end
            end
            ST_START:     state_n = ST_WAIT_LO;
            // A done still high from the previous frame must drop first.
            ST_WAIT_LO:   if (!mm_done) state_n = ST_WAIT_DONE;
            ST_WAIT_DONE: if (mm_done)  state_n = ST_FILL;
            default:      state_n = ST_FILL;
        endcase
    end

    // Interval length is usable only if it evenly tiles the frame.
    always_comb begin
        cfg_div = (cfg_interval_len == 16'd0) ? 32'd1 : {16'd0, cfg_interval_len};
        cfg_rem = N_U32 % cfg_div;
        cfg_ok  = (cfg_interval_len != 16'd0) && ({16'd0, cfg_interval_len} <= N_U32)
                  && (cfg_rem == 32'd0);
    end

    // Frame buffer, pointer, handoff bookkeeping and registered status decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            raw_audio    <= '0;
            interval_len <= INTERVAL_LEN;
            cfg_err      <= 1'b0;
            frame_count  <= 16'd0;
            start        <= 1'b0;
            busy         <= 1'b0;
            s_ready_q    <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept && wr_ptr == PTR_W'(i))
                    raw_audio[i*SAMPLE_W +: SAMPLE_W] <= s_if.s_data;
            end
            if (do_flush || last)
                wr_ptr <= '0;
            else if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            else if (state == ST_WAIT_DONE && mm_done)
                wr_ptr <= '0;
            if (last) begin
                interval_len <= cfg_ok ? cfg_interval_len : INTERVAL_LEN;
                cfg_err      <= !cfg_ok;
                frame_count  <= frame_count + 16'd1;
            end
            start     <= (state_n == ST_START);
            busy      <= (state_n != ST_FILL);
            s_ready_q <= (state_n == ST_FILL);
        end
    end

`ifdef AUDIO_LOADER_CLIP_COUNT_EN
    logic [15:0] clip_acc;
    logic [15:0] clip_next;
    logic        is_clip;

    assign is_clip = ($signed(s_if.s_data) >=  $signed(CLIP_THRESH)) ||
                     ($signed(s_if.s_data) <= -$signed(CLIP_THRESH));
    assign clip_next = (accept && is_clip && clip_acc != 16'hFFFF) ? clip_acc + 16'd1
                                                                    : clip_acc;

    // Saturating per-frame clip tally, published when the frame completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip_acc   <= 16'd0;
            clip_count <= 16'd0;
        end else if (do_flush) begin
            clip_acc <= 16'd0;
        end else if (last) begin
            clip_count <= clip_next;
            clip_acc   <= 16'd0;
        end else if (accept) begin
            clip_acc <= clip_next;
        end
    end
`else
    logic unused_clip_thresh;
    assign unused_clip_thresh = ^CLIP_THRESH;
    assign clip_count = 16'd0;
`endif
endmodule
